// File: rtl/sequence_generator_if.sv
// Handshake and serial-output bundle between a stimulus controller and sequence_generator.
interface sequence_generator_if #(
  parameter int PATTERN_W = 16,
  parameter int LEN_W     = $clog2(PATTERN_W) + 1
);
  logic                 start;
  logic                 step;
  logic [PATTERN_W-1:0] pattern;
  logic [LEN_W-1:0]     len;
  logic                 repeat_en;
  logic                 A_out;
  logic                 busy;
  logic                 done;
  logic [LEN_W-1:0]     bit_cnt;
  logic                 expect_Z;

  modport master (
    output start, step, pattern, len, repeat_en,
    input  A_out, busy, done, bit_cnt, expect_Z
  );

  modport slave (
    input  start, step, pattern, len, repeat_en,
    output A_out, busy, done, bit_cnt, expect_Z
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial stimulus transmitter: shifts a latched pattern out MSB-of-length first, one bit per step.
// Define SEQGEN_GOLDEN_DETECT_EN to build the golden sequence detector driving expect_Z.
module sequence_generator #(
  parameter int                  PATTERN_W  = 16,
  parameter int                  LEN_W      = $clog2(PATTERN_W) + 1,
  parameter int                  DETECT_W   = 4,
  parameter logic [DETECT_W-1:0] DETECT_SEQ = 4'b1011
) (
  input logic                 CLK,
  input logic                 RST_N,
  sequence_generator_if.slave bus
);
  localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]           r_state;
  logic [PATTERN_W-1:0] r_pattern;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_cnt;
  logic                 r_aout;

  logic                 w_lenOk;
  logic                 w_startAccept;
  logic                 w_stepAccept;
  logic [IDX_W-1:0]     w_liveIdx;
  logic [IDX_W-1:0]     w_nextIdx;
  logic [IDX_W-1:0]     w_reloadIdx;

  assign w_lenOk       = (bus.len != '0) && (bus.len <= LEN_W'(PATTERN_W));
  assign w_startAccept = (r_state == S_IDLE) && bus.start && w_lenOk;
  assign w_stepAccept  = (r_state == S_SEND) && bus.step;

  // Indices are only consumed when the count guarantees they are in range, so truncation is safe.
  assign w_liveIdx   = IDX_W'(bus.len - LEN_W'(1));
  assign w_nextIdx   = IDX_W'(r_cnt - LEN_W'(2));
  assign w_reloadIdx = IDX_W'(r_len - LEN_W'(1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_aout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_startAccept) begin
            r_state   <= S_SEND;
            r_pattern <= bus.pattern;
            r_len     <= bus.len;
            r_cnt     <= bus.len;
            r_aout    <= bus.pattern[w_liveIdx];
          end
        end
        S_SEND: begin
          if (w_stepAccept) begin
            if (r_cnt > LEN_W'(1)) begin
              r_cnt  <= r_cnt - LEN_W'(1);
              r_aout <= r_pattern[w_nextIdx];
            end else if (bus.repeat_en) begin
              r_cnt  <= r_len;
              r_aout <= r_pattern[w_reloadIdx];
            end else begin
              r_state <= S_FIN;
              r_cnt   <= '0;
              r_aout  <= 1'b0;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.A_out   = r_aout;
  assign bus.busy    = (r_state == S_SEND);
  assign bus.done    = (r_state == S_FIN);
  assign bus.bit_cnt = r_cnt;

`ifdef SEQGEN_GOLDEN_DETECT_EN
  localparam int DCNT_W = $clog2(DETECT_W + 1);

  logic [DETECT_W-1:0] r_hist;
  logic [DCNT_W-1:0]   r_shifted;

  // The outgoing bit is captured before the step replaces it, so the last bit is seen too.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hist    <= '0;
      r_shifted <= '0;
    end else if (w_startAccept) begin
      r_hist    <= '0;
      r_shifted <= '0;
    end else if (w_stepAccept) begin
      r_hist <= {r_hist[DETECT_W-2:0], r_aout};
      if (r_shifted != DCNT_W'(DETECT_W)) begin
        r_shifted <= r_shifted + DCNT_W'(1);
      end
    end
  end

  assign bus.expect_Z = (r_hist == DETECT_SEQ) && (r_shifted == DCNT_W'(DETECT_W));
`else
  logic w_unusedDetect;

  assign w_unusedDetect = ^DETECT_SEQ;
  assign bus.expect_Z   = 1'b0;
`endif
endmodule
